// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the load/store stage.
//   state_t           - FSM states IDLE / REQ / WAIT / DONE
//   F3_*              - funct3 access-size encodings
//   byte_en()         - byte enables for a memory access
//   is_misaligned()   - alignment check for an access size and address
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Loads always fetch the whole word; lane selection happens on the way back.
  function automatic logic [3:0] byte_en(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    if (is_store) begin
      case (funct3)
        F3_B:    be = 4'b0001 << addr_lo;
        F3_H:    be = 4'b0011 << addr_lo;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Byte accesses never misalign; unknown load sizes are handled as words.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic is_byte;
    logic is_half;
    is_byte = is_store ? (funct3 == F3_B) : (funct3 == F3_B || funct3 == F3_BU);
    is_half = is_store ? (funct3 == F3_H) : (funct3 == F3_H || funct3 == F3_HU);
    if (is_byte)      return 1'b0;
    else if (is_half) return addr_lo[0];
    else              return |addr_lo;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a loaded word and
// sign- or zero-extends it to DATA_WIDTH.
//   i_rdata    - raw data word from memory
//   i_addr_lo  - address bits [1:0] of the access
//   i_funct3   - load size/sign encoding (unknown encodings act as LW)
//   o_data     - extended load result
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_addr_lo,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  // Halfword loads reaching here are aligned, so addr[1] alone picks the lane.
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_H:    o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipelined load/store stage downstream of the ALU.
//   in_valid/in_ready    - upstream handshake; accepts only when idle
//   ALUout, store_data   - address (or pass-through result) and store data
//   mem_read/mem_write   - access type (both set is handled as a load)
//   funct3, rd, reg_write- access size/sign and destination register
//   out_valid/out_ready  - downstream handshake for the registered result
//   out_result, out_rd, out_reg_write, out_misaligned - writeback fields
//   dmem_*               - req/gnt/rvalid data-memory port
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     ALUout,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                funct3,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_misaligned,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata
);

  state_t r_state;
  state_t w_next_state;

  logic                      r_is_load;
  logic [2:0]                r_funct3;
  logic [1:0]                r_addr_lo;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_reg_write;
  logic                      r_misaligned;
  logic                      r_dmem_we;
  logic [DATA_WIDTH-1:0]     r_dmem_addr;
  logic [3:0]                r_dmem_be;
  logic [DATA_WIDTH-1:0]     r_dmem_wdata;

  logic                      w_accept;
  logic                      w_is_mem;
  logic                      w_is_load;
  logic                      w_is_store;
  logic                      w_mis;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [DATA_WIDTH-1:0]     w_load_ext;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_is_mem   = mem_read || mem_write;
  // A load takes precedence when both controls are set.
  assign w_is_load  = mem_read;
  assign w_is_store = mem_write && !mem_read;
  assign w_mis      = w_is_mem && is_misaligned(w_is_store, funct3, ALUout[1:0]);

  // Store data replicated across every lane it could land in.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_wdata = store_data;
    case (funct3)
      F3_B:    w_wdata = {4{store_data[7:0]}};
      F3_H:    w_wdata = {2{store_data[15:0]}};
      default: w_wdata = store_data;
    endcase
  end

  load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_ext)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next_state = (!w_is_mem || w_mis) ? DONE : REQ;
      REQ:  if (dmem_gnt) w_next_state = r_is_load ? WAIT : DONE;
      WAIT: if (dmem_rvalid) w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (r_state == IDLE);
    dmem_req  = (r_state == REQ);
    out_valid = (r_state == DONE);
  end

  // Datapath: everything is latched on accept and held stable until the next
  // accept, which keeps the memory request fields steady while waiting for gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load    <= 1'b0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_result     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_misaligned <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= '0;
      r_dmem_wdata <= '0;
    end else if (w_accept) begin
      r_is_load    <= w_is_load;
      r_funct3     <= funct3;
      r_addr_lo    <= ALUout[1:0];
      r_result     <= ALUout;
      r_rd         <= rd;
      // Stores and faulting accesses never write back.
      r_reg_write  <= reg_write && !w_is_store && !w_mis;
      r_misaligned <= w_mis;
      r_dmem_we    <= w_is_store && !w_mis;
      r_dmem_addr  <= {ALUout[DATA_WIDTH-1:2], 2'b00};
      r_dmem_be    <= (w_is_mem && !w_mis) ? byte_en(w_is_store, funct3, ALUout[1:0]) : 4'b0000;
      r_dmem_wdata <= (w_is_store && !w_mis) ? w_wdata : '0;
    end else if (r_state == WAIT && dmem_rvalid) begin
      r_result     <= w_load_ext;
    end
  end

  assign out_result     = r_result;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_misaligned = r_misaligned;
  assign dmem_we        = r_dmem_we;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_be        = r_dmem_be;
  assign dmem_wdata     = r_dmem_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard-driven bench for mem_stage. Expected writeback
// records are queued as each operation is accepted and compared when the
// stage presents its result.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUout;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        chk;   // compare out_result only when it is defined
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ALUout         (ALUout),
    .store_data     (store_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .rd             (rd),
    .reg_write      (reg_write),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_misaligned (out_misaligned),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after accept.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd,
                       input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [4:0] rd_v, input logic rw, input exp_t e);
    int guard;
    in_valid = 1'b1; ALUout = alu; store_data = sd; mem_read = mr;
    mem_write = mw; funct3 = f3; rd = rd_v; reg_write = rw;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    ALUout = 32'h5A5A_5A5A; store_data = 32'hA5A5_A5A5; reg_write = 1'b0;
  endtask

  // Acts as the memory; starts in the first REQ cycle.
  task automatic serve(input bit is_load, input int gnt_dly, input int rv_dly,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] rdata);
    for (int i = 0; i <= gnt_dly; i++) begin
      check("req_high", 32'(dmem_req), 32'd1);
      check("req_addr", dmem_addr, exp_addr);
      check("req_be", 32'(dmem_be), 32'(exp_be));
      check("req_we", 32'(dmem_we), 32'(!is_load));
      if (!is_load) check("req_wdata", dmem_wdata, exp_wdata);
      check("req_no_valid", 32'(out_valid), 32'd0);
      if (i == gnt_dly) dmem_gnt = 1'b1;
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    check("req_drop", 32'(dmem_req), 32'd0);
    if (is_load) begin
      for (int i = 0; i <= rv_dly; i++) begin
        check("wait_no_valid", 32'(out_valid), 32'd0);
        if (i == rv_dly) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdata;
        end
        @(negedge clk);
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  // Pops the scoreboard and checks the writeback, optionally with backpressure.
  task automatic collect(input int hold);
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.result = 'x; e.rd = 'x; e.rw = 1'bx; e.mis = 1'bx; e.chk = 1'b1;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      if (e.chk) check("bp_result", out_result, e.result);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (e.chk) check("out_result", out_result, e.result);
    check("out_rd", 32'(out_rd), 32'(e.rd));
    check("out_reg_write", 32'(out_reg_write), 32'(e.rw));
    check("out_misaligned", 32'(out_misaligned), 32'(e.mis));
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic do_nomem(input logic [31:0] alu, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [4:0] rd_v,
                          input logic rw, input exp_t e);
    issue(alu, 32'h0, mr, mw, f3, rd_v, rw, e);
    check("no_req", 32'(dmem_req), 32'd0);
    collect(0);
  endtask

  task automatic do_store(input logic [31:0] alu, input logic [31:0] sd,
                          input logic [2:0] f3, input logic [4:0] rd_v,
                          input int gnt_dly, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    exp_t e;
    e = '{result: 32'h0, rd: rd_v, rw: 1'b0, mis: 1'b0, chk: 1'b0};
    issue(alu, sd, 1'b0, 1'b1, f3, rd_v, 1'b1, e);
    serve(1'b0, gnt_dly, 0, {alu[31:2], 2'b00}, exp_be, exp_wdata, 32'h0);
    collect(0);
  endtask

  task automatic do_load(input logic [31:0] alu, input logic mw, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp_res,
                         input logic [4:0] rd_v, input int gnt_dly,
                         input int rv_dly, input int hold);
    exp_t e;
    e = '{result: exp_res, rd: rd_v, rw: 1'b1, mis: 1'b0, chk: 1'b1};
    issue(alu, 32'h0, 1'b1, mw, f3, rd_v, 1'b1, e);
    serve(1'b1, gnt_dly, rv_dly, {alu[31:2], 2'b00}, 4'b1111, 32'h0, rdata);
    collect(hold);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ALUout = '0; store_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; rd = '0; reg_write = 1'b0;
    out_ready = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", out_result, 32'h0);
    check("rst_dmem_be", 32'(dmem_be), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU pass-through
    do_nomem(32'h0000_1234, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1,
             '{result: 32'h0000_1234, rd: 5'd5, rw: 1'b1, mis: 1'b0, chk: 1'b1});

    // Stores: SB with late gnt, SH, SW
    do_store(32'h0000_0103, 32'hAABB_CCDD, 3'b000, 5'd7, 2, 4'b1000, 32'hDDDD_DDDD);
    do_store(32'h0000_0102, 32'h1234_5678, 3'b001, 5'd8, 0, 4'b1100, 32'h5678_5678);
    do_store(32'h0000_0104, 32'hCAFE_F00D, 3'b010, 5'd9, 1, 4'b1111, 32'hCAFE_F00D);

    // Loads against 0x80F0_7F01
    do_load(32'h0000_0202, 1'b0, 3'b000, 32'h80F0_7F01, 32'hFFFF_FFF0, 5'd10, 0, 0, 0);
    do_load(32'h0000_0202, 1'b0, 3'b100, 32'h80F0_7F01, 32'h0000_00F0, 5'd11, 1, 1, 0);
    do_load(32'h0000_0202, 1'b0, 3'b001, 32'h80F0_7F01, 32'hFFFF_80F0, 5'd12, 0, 2, 0);
    do_load(32'h0000_0202, 1'b0, 3'b101, 32'h80F0_7F01, 32'h0000_80F0, 5'd13, 0, 0, 0);
    do_load(32'h0000_0201, 1'b0, 3'b000, 32'h80F0_7F01, 32'h0000_007F, 5'd14, 0, 0, 0);
    do_load(32'h0000_0203, 1'b0, 3'b100, 32'h80F0_7F01, 32'h0000_0080, 5'd15, 0, 0, 0);
    do_load(32'h0000_0200, 1'b0, 3'b001, 32'h80F0_7F01, 32'h0000_7F01, 5'd16, 0, 0, 0);
    do_load(32'h0000_0208, 1'b0, 3'b011, 32'h80F0_7F01, 32'h80F0_7F01, 5'd17, 0, 0, 0);
    // mem_read && mem_write acts as a load
    do_load(32'h0000_0600, 1'b1, 3'b010, 32'h1357_9BDF, 32'h1357_9BDF, 5'd18, 0, 0, 0);

    // Misaligned LW and LH
    do_nomem(32'h0000_0305, 1'b1, 1'b0, 3'b010, 5'd19, 1'b1,
             '{result: 32'h0, rd: 5'd19, rw: 1'b0, mis: 1'b1, chk: 1'b0});
    do_nomem(32'h0000_0301, 1'b1, 1'b0, 3'b001, 5'd20, 1'b1,
             '{result: 32'h0, rd: 5'd20, rw: 1'b0, mis: 1'b1, chk: 1'b0});

    // Backpressure on a completed load
    do_load(32'h0000_0500, 1'b0, 3'b010, 32'hCAFE_BABE, 32'hCAFE_BABE, 5'd21, 1, 2, 4);

    // Reset while in WAIT, then a late rvalid
    issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b010, 5'd22, 1'b1,
          '{result: 32'h0, rd: 5'd22, rw: 1'b1, mis: 1'b0, chk: 1'b1});
    check("rst_test_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_dmem_req", 32'(dmem_req), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_rd", 32'(out_rd), 32'd0);
    check("arst_out_result", out_result, 32'h0);
    check("arst_dmem_addr", dmem_addr, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rvalid_out_valid", 32'(out_valid), 32'd0);
    check("late_rvalid_in_ready", 32'(in_ready), 32'd1);
    check("late_rvalid_result", out_result, 32'h0);
    do_load(32'h0000_0404, 1'b0, 3'b010, 32'h1234_5678, 32'h1234_5678, 5'd23, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipelined load/store stage sitting directly downstream of the ALU in the execute path.
- Captures the ALU result (used as the effective address or passed through as the result), store data and memory controls.
- Runs a req/gnt/rvalid transaction on the data-memory port, applies byte-lane steering and load sign/zero extension.
- Presents a registered writeback result to the next stage under a valid/ready handshake, stalling upstream while a memory access is outstanding.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width
- REG_ADDR_WIDTH, 5, destination register index width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream holds a valid operation
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- ALUout  in  DATA_WIDTH  ALU result: address for loads/stores, result otherwise
- store_data  in  DATA_WIDTH  rs2 value for stores
- mem_read  in  1  operation is a load
- mem_write  in  1  operation is a store (mem_read && mem_write is illegal, treated as load)
- funct3  in  3  access size/sign
- rd  in  REG_ADDR_WIDTH  destination register
- reg_write  in  1  operation writes rd
- out_valid  out  1  writeback result valid
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- out_result  out  DATA_WIDTH  load data or passed-through ALUout
- out_rd  out  REG_ADDR_WIDTH  registered rd
- out_reg_write  out  1  registered reg_write, forced 0 on misalign
- out_misaligned  out  1  access was misaligned, no memory request issued
- dmem_req  out  1  memory request, held until dmem_gnt
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_WIDTH  word-aligned address (ALUout with bits [1:0] cleared)
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DATA_WIDTH  load data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state: IDLE; every output register is 0.
- in_ready = (state == IDLE).
- IDLE, on accept: latch all inputs.
  - Non-memory op: go to DONE, out_result = ALUout.
  - Misaligned memory op: go to DONE with out_misaligned = 1, out_reg_write = 0, no dmem_req.
    - Halfword: addr[0] = 1.
    - Word: addr[1:0] != 0.
  - Otherwise: go to REQ.
- REQ: dmem_req = 1 with addr/we/be/wdata stable until dmem_gnt.
  - Store + gnt: go to DONE.
  - Load + gnt: go to WAIT.
- WAIT: on dmem_rvalid, capture the extended load value, go to DONE. dmem_rvalid outside WAIT is ignored.
- DONE: out_valid = 1; on out_ready, go to IDLE.
- Store encodings: funct3 000 SB, 001 SH, 010 SW; dmem_be = 0001<<addr[1:0], 0011<<addr[1:0], 1111.
  - wdata byte replicated ×4, half replicated ×2, word as-is.
- Load encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other funct3 is treated as LW.
  - Lane selected by addr[1:0]; sign- or zero-extended to DATA_WIDTH. Loads use dmem_be = 1111.
- Stores complete with out_reg_write = 0, regardless of the input reg_write.

## Timing
- Non-memory or misaligned op accepted in cycle N: out_valid in N+1.
- Store: dmem_req first high in N+1. With gnt in cycle G: out_valid in G+1.
- Load: rvalid no earlier than G+1. With rvalid in cycle R: out_valid in R+1. Minimum latency 3 cycles.
- Throughput: one operation per 2 cycles at best; no new accept while out_valid is held by out_ready = 0.
- Asynchronous reset mid-transaction: immediately IDLE, dmem_req = 0, out_valid = 0. A late rvalid after reset is ignored.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - a function computing byte enables.
- Sub-module load_extend (combinational): inputs dmem_rdata, addr[1:0], funct3; output extended word. Instantiated once.

## Test plan
- ALU pass-through: ALUout = 0x0000_1234, mem_read = mem_write = 0, rd = 5, reg_write = 1 -> out_valid next cycle, out_result = 0x1234, out_rd = 5, no dmem_req.
- SB: ALUout = 0x103, store_data = 0xAABB_CCDD, funct3 = 000, gnt 2 cycles late -> dmem_req held 3 cycles, dmem_addr = 0x100, dmem_be = 1000, dmem_wdata = 0xDDDD_DDDD, out_valid the cycle after gnt, out_reg_write = 0.
- LB/LBU/LH: dmem_rdata = 0x80F0_7F01.
  - LB at 0x202 -> 0xFFFF_FFF0.
  - LBU at 0x202 -> 0x0000_00F0.
  - LH at 0x202 -> 0xFFFF_80F0.
- Misaligned LW at 0x305 -> no dmem_req, out_valid next cycle, out_misaligned = 1, out_reg_write = 0.
- Backpressure: out_ready = 0 for 4 cycles after a load completes -> out_valid and out_result stable, in_ready = 0 throughout.
- Reset asserted in WAIT, then rvalid pulsed after release -> all outputs 0, state IDLE, rvalid ignored, next op accepted normally.
